// File: rtl/xosera_bus_host.sv
// Host-side initiator for the Xosera 8-bit register bus. Each 16-bit request
// becomes up to two SETUP/STROBE/HOLD byte cycles, even byte first.
module xosera_bus_host #(
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned STROBE_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES   = 1
) (
  input  logic        clk,
  input  logic        reset_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [3:0]  req_reg_i,
  input  logic [1:0]  req_mask_i,
  input  logic [15:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [15:0] rsp_rdata_o,
  output logic        busy_o,
  output logic        bus_cs_n_o,
  output logic        bus_rd_nwr_o,
  output logic        bus_bytesel_o,
  output logic [3:0]  bus_reg_num_o,
  output logic [7:0]  bus_data_o,
  output logic        bus_data_oe_o,
  input  logic [7:0]  bus_data_i
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYCLES - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic        wr_q;
  logic        odd_q;
  logic [1:0]  mask_q;
  logic [15:0] wdata_q;
  logic [15:0] rdata_q;

  assign req_ready_o = (state == IDLE) && reset_n_i;

  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      state         <= IDLE;
      cnt           <= '0;
      wr_q          <= 1'b0;
      odd_q         <= 1'b0;
      mask_q        <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      rsp_valid_o   <= 1'b0;
      rsp_rdata_o   <= '0;
      busy_o        <= 1'b0;
      bus_cs_n_o    <= 1'b1;
      bus_rd_nwr_o  <= 1'b1;
      bus_bytesel_o <= 1'b0;
      bus_reg_num_o <= '0;
      bus_data_o    <= '0;
      bus_data_oe_o <= 1'b0;
    end else begin
      rsp_valid_o <= 1'b0;
      case (state)
        IDLE: if (req_valid_i) begin
          wr_q    <= req_write_i;
          mask_q  <= req_mask_i;
          wdata_q <= req_wdata_i;
          rdata_q <= '0;
          busy_o  <= 1'b1;
          if (req_mask_i == 2'b00) begin
            state       <= DONE;
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= '0;
          end else begin
            // Bus fields are launched here so they are already stable in the first SETUP cycle.
            state         <= SETUP;
            cnt           <= SETUP_LD;
            odd_q         <= ~req_mask_i[1];
            bus_bytesel_o <= ~req_mask_i[1];
            bus_reg_num_o <= req_reg_i;
            bus_rd_nwr_o  <= ~req_write_i;
            bus_data_oe_o <= req_write_i;
            if (req_write_i)
              bus_data_o <= req_mask_i[1] ? req_wdata_i[15:8] : req_wdata_i[7:0];
          end
        end
        SETUP: if (cnt == '0) begin
          state      <= STROBE;
          cnt        <= STROBE_LD;
          bus_cs_n_o <= 1'b0;
        end else begin
          cnt <= cnt - 4'd1;
        end
        STROBE: if (cnt == '0) begin
          state      <= HOLD;
          cnt        <= HOLD_LD;
          bus_cs_n_o <= 1'b1;
          if (!wr_q) begin
            if (odd_q) rdata_q[7:0]  <= bus_data_i;
            else       rdata_q[15:8] <= bus_data_i;
          end
        end else begin
          cnt <= cnt - 4'd1;
        end
        HOLD: if (cnt == '0) begin
          if (!odd_q && mask_q[0]) begin
            state         <= SETUP;
            cnt           <= SETUP_LD;
            odd_q         <= 1'b1;
            bus_bytesel_o <= 1'b1;
            if (wr_q) bus_data_o <= wdata_q[7:0];
          end else begin
            state         <= DONE;
            bus_data_oe_o <= 1'b0;
            rsp_valid_o   <= 1'b1;
            rsp_rdata_o   <= rdata_q;
          end
        end else begin
          cnt <= cnt - 4'd1;
        end
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xosera_bus_host.sv
// Randomized bench for xosera_bus_host: two instances (default and S=2/T=1/H=3
// timing) checked every cycle against a timeline model built from accept times.
module tb_xosera_bus_host;

  localparam int SP[2] = '{1, 2};
  localparam int TP[2] = '{4, 1};
  localparam int HP[2] = '{1, 3};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rstn, vld, rdy, wr, rsp_v, busy, cs_n, rd_nwr, bsel, oe;
  logic [1:0][3:0]  rreg, reg_num;
  logic [1:0][1:0]  msk;
  logic [1:0][15:0] wd, rdata;
  logic [1:0][7:0]  dout, din, rev, rod, m_ev, m_od;
  logic [7:0]       junk;

  xosera_bus_host dut0 (
    .clk(clk), .reset_n_i(rstn[0]), .req_valid_i(vld[0]), .req_ready_o(rdy[0]),
    .req_write_i(wr[0]), .req_reg_i(rreg[0]), .req_mask_i(msk[0]), .req_wdata_i(wd[0]),
    .rsp_valid_o(rsp_v[0]), .rsp_rdata_o(rdata[0]), .busy_o(busy[0]),
    .bus_cs_n_o(cs_n[0]), .bus_rd_nwr_o(rd_nwr[0]), .bus_bytesel_o(bsel[0]),
    .bus_reg_num_o(reg_num[0]), .bus_data_o(dout[0]), .bus_data_oe_o(oe[0]),
    .bus_data_i(din[0]));

  xosera_bus_host #(.SETUP_CYCLES(2), .STROBE_CYCLES(1), .HOLD_CYCLES(3)) dut1 (
    .clk(clk), .reset_n_i(rstn[1]), .req_valid_i(vld[1]), .req_ready_o(rdy[1]),
    .req_write_i(wr[1]), .req_reg_i(rreg[1]), .req_mask_i(msk[1]), .req_wdata_i(wd[1]),
    .rsp_valid_o(rsp_v[1]), .rsp_rdata_o(rdata[1]), .busy_o(busy[1]),
    .bus_cs_n_o(cs_n[1]), .bus_rd_nwr_o(rd_nwr[1]), .bus_bytesel_o(bsel[1]),
    .bus_reg_num_o(reg_num[1]), .bus_data_o(dout[1]), .bus_data_oe_o(oe[1]),
    .bus_data_i(din[1]));

  // Responder: drives the op's byte values only while selected for a read.
  always_comb begin
    for (int i = 0; i < 2; i++)
      din[i] = (!cs_n[i] && rd_nwr[i]) ? (bsel[i] ? m_od[i] : m_ev[i]) : junk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0, nerr = 0;

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s inst%0d cyc%0d got %0h want %0h", nm, i, cyc, act, exp);
    end
  endtask

  // Model state: one in-flight op per instance, described by its accept cycle.
  bit          op_act[2] = '{0, 0};
  bit          after_rst[2] = '{1, 1};
  int          op_k[2];
  logic        op_w[2];
  logic [3:0]  op_r[2];
  logic [1:0]  op_m[2];
  logic [15:0] op_d[2];
  int          lowcnt[2] = '{0, 0};
  int          oecnt[2] = '{0, 0};
  int          rsp_cnt[2] = '{0, 0};
  int          last_rsp_cyc[2];
  logic [15:0] last_rsp_data[2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int d, b, p, o, bi;
      bit odd, idle_p;
      logic [15:0] erd;
      p = SP[i] + TP[i] + HP[i];
      b = int'(op_m[i][1]) + int'(op_m[i][0]);
      d = cyc - op_k[i];
      idle_p = 1;
      if (cs_n[i] == 1'b0) lowcnt[i]++;
      if (oe[i] == 1'b1) oecnt[i]++;
      if (rsp_v[i] == 1'b1) begin
        rsp_cnt[i]++;
        last_rsp_cyc[i] = cyc;
        last_rsp_data[i] = rdata[i];
      end
      if (after_rst[i]) begin
        chk("rst_cs_n", i, cs_n[i], 1);    chk("rst_rd_nwr", i, rd_nwr[i], 1);
        chk("rst_bytesel", i, bsel[i], 0); chk("rst_reg", i, reg_num[i], 0);
        chk("rst_data", i, dout[i], 0);    chk("rst_oe", i, oe[i], 0);
        chk("rst_rsp_v", i, rsp_v[i], 0);  chk("rst_rdata", i, rdata[i], 0);
        chk("rst_busy", i, busy[i], 0);    chk("rst_ready", i, rdy[i], rstn[i]);
        after_rst[i] = 0;
      end else if (op_act[i] && d >= 1 && d <= b * p) begin
        idle_p = 0;
        bi  = (d - 1) / p;
        o   = (d - 1) % p;
        odd = !(bi == 0 && op_m[i][1]);
        chk("cs_n", i, cs_n[i], !(o >= SP[i] && o < SP[i] + TP[i]));
        chk("oe", i, oe[i], op_w[i]);
        chk("rd_nwr", i, rd_nwr[i], !op_w[i]);
        chk("bytesel", i, bsel[i], odd);
        chk("reg_num", i, reg_num[i], op_r[i]);
        if (op_w[i]) chk("wdata", i, dout[i], odd ? op_d[i][7:0] : op_d[i][15:8]);
        chk("busy", i, busy[i], 1);
        chk("rsp_v", i, rsp_v[i], 0);
        chk("ready", i, rdy[i], 0);
      end else if (op_act[i] && d == b * p + 1) begin
        idle_p = 0;
        erd = op_w[i] ? 16'h0 : {op_m[i][1] ? m_ev[i] : 8'h0, op_m[i][0] ? m_od[i] : 8'h0};
        chk("rsp_v", i, rsp_v[i], 1);
        chk("rdata", i, rdata[i], erd);
        chk("done_cs_n", i, cs_n[i], 1);
        chk("done_oe", i, oe[i], 0);
        chk("done_busy", i, busy[i], 1);
        chk("done_ready", i, rdy[i], 0);
      end else begin
        chk("idle_cs_n", i, cs_n[i], 1);
        chk("idle_oe", i, oe[i], 0);
        chk("idle_rsp_v", i, rsp_v[i], 0);
        chk("idle_busy", i, busy[i], 0);
        chk("idle_ready", i, rdy[i], rstn[i]);
      end
      if (!rstn[i]) begin
        op_act[i] = 0;
        after_rst[i] = 1;
      end else if (idle_p && vld[i]) begin
        op_act[i] = 1;
        op_k[i] = cyc;
        op_w[i] = wr[i]; op_r[i] = rreg[i]; op_m[i] = msk[i]; op_d[i] = wd[i];
        m_ev[i] = rev[i]; m_od[i] = rod[i];
      end
    end
    junk = 8'($urandom);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble(input int i);
    wr[i] = 1'($urandom); rreg[i] = 4'($urandom); msk[i] = 2'($urandom); wd[i] = 16'($urandom);
  endtask

  task automatic do_req(input int i, input logic w, input logic [3:0] r, input logic [1:0] m,
                        input logic [15:0] d, input logic [7:0] ev, input logic [7:0] od,
                        input bit keep, output int k);
    bit took;
    int n;
    wr[i] = w; rreg[i] = r; msk[i] = m; wd[i] = d; rev[i] = ev; rod[i] = od; vld[i] = 1'b1;
    took = 0; n = 0; k = -1;
    while (!took && n < 200) begin
      @(negedge clk);
      took = rdy[i] && rstn[i];
      k = cyc;
      step();
      n++;
    end
    chk("accept_timeout", i, took, 1);
    if (keep) scramble(i);
    else vld[i] = 1'b0;
  endtask

  task automatic wait_rsp(input int i, input int n0);
    int n;
    n = 0;
    while (rsp_cnt[i] <= n0 && n < 300) begin
      step();
      n++;
    end
    chk("rsp_timeout", i, rsp_cnt[i] > n0, 1);
  endtask

  initial begin
    int k, k2, n0, lo, oc, krst;
    rstn = '0; vld = '0; wr = '0; rreg = '0; msk = '0; wd = '0; rev = '0; rod = '0;
    m_ev = '0; m_od = '0; junk = '0;
    repeat (3) step();
    rstn = 2'b11;
    step();

    // Word write, reg 3
    n0 = rsp_cnt[0]; lo = lowcnt[0]; oc = oecnt[0];
    do_req(0, 1, 4'd3, 2'b11, 16'hA55A, 8'h0, 8'h0, 0, k);
    wait_rsp(0, n0);
    chk("t1_lat", 0, last_rsp_cyc[0] - k, 13);
    chk("t1_rdata", 0, last_rsp_data[0], 16'h0000);
    chk("t1_low", 0, lowcnt[0] - lo, 8);
    chk("t1_oe", 0, oecnt[0] - oc, 12);

    // Word read, reg 9
    n0 = rsp_cnt[0]; oc = oecnt[0];
    do_req(0, 0, 4'd9, 2'b11, 16'hFFFF, 8'h12, 8'h34, 0, k);
    wait_rsp(0, n0);
    chk("t2_lat", 0, last_rsp_cyc[0] - k, 13);
    chk("t2_rdata", 0, last_rsp_data[0], 16'h1234);
    chk("t2_oe", 0, oecnt[0] - oc, 0);

    // Odd-byte write
    n0 = rsp_cnt[0]; lo = lowcnt[0];
    do_req(0, 1, 4'd6, 2'b01, 16'h00C3, 8'h0, 8'h0, 0, k);
    wait_rsp(0, n0);
    chk("t3_lat", 0, last_rsp_cyc[0] - k, 7);
    chk("t3_low", 0, lowcnt[0] - lo, 4);

    // Empty mask, then an immediate even-byte read
    n0 = rsp_cnt[0]; lo = lowcnt[0];
    do_req(0, 0, 4'd1, 2'b00, 16'h0, 8'hEE, 8'hDD, 0, k);
    do_req(0, 0, 4'd2, 2'b10, 16'h0, 8'h9C, 8'h11, 0, k2);
    chk("t4_lat", 0, last_rsp_cyc[0] - k, 1);
    chk("t4_rdata", 0, last_rsp_data[0], 16'h0000);
    chk("t4_low", 0, lowcnt[0] - lo, 0);
    chk("t4_next", 0, k2 - k, 2);
    wait_rsp(0, n0 + 1);
    chk("t4b_rdata", 0, last_rsp_data[0], 16'h9C00);

    // Reset during the second strobe of a word write; valid held through reset
    do_req(0, 1, 4'd7, 2'b11, 16'h5AA5, 8'h0, 8'h0, 0, k);
    repeat (8) step();
    krst = cyc;
    n0 = rsp_cnt[0];
    wr[0] = 1'b0; rreg[0] = 4'd2; msk[0] = 2'b11; rev[0] = 8'h77; rod[0] = 8'h88; vld[0] = 1'b1;
    rstn[0] = 1'b0;
    step();
    rstn[0] = 1'b1;
    do_req(0, 0, 4'd2, 2'b11, 16'h0, 8'h77, 8'h88, 0, k2);
    chk("t5_accept", 0, k2 - krst, 1);
    wait_rsp(0, n0);
    chk("t5_lat", 0, last_rsp_cyc[0] - k2, 13);
    chk("t5_rdata", 0, last_rsp_data[0], 16'h7788);

    // S=2/T=1/H=3, valid held, fields scrambled mid-op
    n0 = rsp_cnt[1]; lo = lowcnt[1];
    do_req(1, 1, 4'd5, 2'b11, 16'hBEEF, 8'h0, 8'h0, 1, k);
    repeat (8) begin scramble(1); step(); end
    do_req(1, 0, 4'hA, 2'b11, 16'h0, 8'h5A, 8'hC3, 1, k2);
    chk("t6_b2b", 1, k2 - k, 14);
    chk("t6_lat1", 1, last_rsp_cyc[1] - k, 13);
    wait_rsp(1, n0 + 1);
    vld[1] = 1'b0;
    chk("t6_lat2", 1, last_rsp_cyc[1] - k, 27);
    chk("t6_rdata", 1, last_rsp_data[1], 16'h5AC3);
    chk("t6_low", 1, lowcnt[1] - lo, 4);
    repeat (20) step();

    // Random traffic with occasional resets
    for (int n = 0; n < 160; n++) begin
      int i;
      bit keep;
      i = int'($urandom_range(1));
      keep = ($urandom_range(3) == 0);
      do_req(i, 1'($urandom), 4'($urandom), 2'($urandom), 16'($urandom),
             8'($urandom), 8'($urandom), keep, k);
      repeat ($urandom_range(16)) step();
      if ($urandom_range(9) == 0) begin
        rstn[i] = 1'b0;
        step();
        rstn[i] = 1'b1;
      end
    end
    vld = '0;
    repeat (40) step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
